// File: rtl/logs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : logs_pkg
// Brief    : State encoding and default parameters for the envelope stage.
// Revision : 1.0
// ============================================================================
package logs_pkg;

  localparam int unsigned  C_DEF_ENV_BITS  = 8;
  localparam logic [15:0]  C_DEF_ATK_DIV   = 16'd1024;
  localparam logic [15:0]  C_DEF_REL_DIV   = 16'd4096;
  localparam logic [7:0]   C_DEF_SUS_LEVEL = 8'd192;
  localparam int unsigned  C_CNT_BITS      = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ATTACK  = 2'd1,
    ST_SUSTAIN = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

endpackage : logs_pkg
`default_nettype wire

// File: rtl/logs_pdm_dither.sv
`default_nettype none
// ============================================================================
// Module   : logs_pdm_dither
// Brief    : First-order PDM: carry of acc+level, registered, drives en.
// Revision : 1.0
// ============================================================================
module logs_pdm_dither
  import logs_pkg::*;
#(
  parameter int unsigned ENV_BITS = C_DEF_ENV_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ENV_BITS-1:0] level,
  output logic                en
);

  logic [ENV_BITS-1:0] r_acc;
  logic                r_en;
  logic [ENV_BITS:0]   w_sum;

  assign w_sum = {1'b0, r_acc} + {1'b0, level};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_en  <= 1'b0;
    end else begin
      r_acc <= w_sum[ENV_BITS-1:0];
      r_en  <= w_sum[ENV_BITS];
    end
  end

  assign en = r_en;

endmodule : logs_pdm_dither
`default_nettype wire

// File: rtl/logs_envelope.sv
`default_nettype none
// ============================================================================
// Module   : logs_envelope
// Brief    : ASR envelope gating a 1-bit PWM stream through PDM dither.
// Revision : 1.0
// ============================================================================
module logs_envelope
  import logs_pkg::*;
#(
  parameter int unsigned         ENV_BITS  = C_DEF_ENV_BITS,
  parameter logic [15:0]         ATK_DIV   = C_DEF_ATK_DIV,
  parameter logic [15:0]         REL_DIV   = C_DEF_REL_DIV,
  parameter logic [ENV_BITS-1:0] SUS_LEVEL = ENV_BITS'(C_DEF_SUS_LEVEL)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                snd_in,
  input  logic                gate,
  output logic                snd_out,
  output logic [ENV_BITS-1:0] env_level,
  output logic                busy
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ENV_BITS-1:0]   r_level;
  logic [ENV_BITS-1:0]   w_level_nxt;
  logic [ENV_BITS-1:0]   w_level_inc;
  logic [ENV_BITS-1:0]   w_level_dec;
  logic [C_CNT_BITS-1:0] r_count;
  logic [C_CNT_BITS-1:0] w_count_nxt;
  logic [C_CNT_BITS-1:0] w_div;
  logic                  w_stepping;
  logic                  w_tick;
  logic                  w_en;
  logic                  r_snd_out;

  assign w_stepping  = (r_state == ST_ATTACK) || (r_state == ST_RELEASE);
  assign w_div       = (r_state == ST_ATTACK) ? ATK_DIV : REL_DIV;
  assign w_tick      = w_stepping && (r_count == (w_div - 16'd1));
  assign w_level_inc = r_level + ENV_BITS'(1);
  assign w_level_dec = r_level - ENV_BITS'(1);

  // Abort/retrigger on gate outranks both the tick and the bound checks.
  always_comb begin
    w_state_nxt = r_state;
    w_level_nxt = r_level;
    case (r_state)
      ST_IDLE: begin
        w_level_nxt = '0;
        if (gate) w_state_nxt = ST_ATTACK;
      end
      ST_ATTACK: begin
        if (!gate) begin
          w_state_nxt = ST_RELEASE;
        end else if (r_level >= SUS_LEVEL) begin
          w_state_nxt = ST_SUSTAIN;
          w_level_nxt = SUS_LEVEL;
        end else if (w_tick) begin
          w_level_nxt = w_level_inc;
          if (w_level_inc == SUS_LEVEL) w_state_nxt = ST_SUSTAIN;
        end
      end
      ST_SUSTAIN: begin
        if (!gate) w_state_nxt = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (gate) begin
          w_state_nxt = ST_ATTACK;
        end else if (r_level == '0) begin
          w_state_nxt = ST_IDLE;
        end else if (w_tick) begin
          w_level_nxt = w_level_dec;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_level_nxt = '0;
      end
    endcase
  end

  always_comb begin
    w_count_nxt = '0;
    if (w_stepping && (w_state_nxt == r_state) && !w_tick) begin
      w_count_nxt = r_count + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_level   <= '0;
      r_count   <= '0;
      r_snd_out <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_level   <= w_level_nxt;
      r_count   <= w_count_nxt;
      r_snd_out <= snd_in & w_en;
    end
  end

  logs_pdm_dither #(
    .ENV_BITS (ENV_BITS)
  ) u_dither (
    .clk   (clk),
    .rst_n (rst_n),
    .level (r_level),
    .en    (w_en)
  );

  assign snd_out   = r_snd_out;
  assign env_level = r_level;
  assign busy      = (r_state != ST_IDLE);

endmodule : logs_envelope
`default_nettype wire

// File: tb/tb_logs_envelope.sv
`default_nettype none
// ============================================================================
// Module   : tb_logs_envelope
// Brief    : Directed scoreboard bench for logs_envelope (ATK 4, REL 8, SUS 16).
// Revision : 1.0
// ============================================================================
module tb_logs_envelope;
  import logs_pkg::*;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       snd_in = 1'b0;
  logic       gate   = 1'b0;
  logic       snd_out;
  logic [7:0] env_level;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  logs_envelope #(
    .ENV_BITS  (8),
    .ATK_DIV   (16'd4),
    .REL_DIV   (16'd8),
    .SUS_LEVEL (8'd16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .snd_in    (snd_in),
    .gate      (gate),
    .snd_out   (snd_out),
    .env_level (env_level),
    .busy      (busy)
  );

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input string tag, input logic [31:0] e);
    exp_t item;
    item.tag = tag;
    item.exp = e;
    sb.push_back(item);
  endtask

  task automatic compare(input logic [31:0] obs);
    exp_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty: observed %0d required <none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        n_err++;
        $error("FAIL %s: observed %0d required %0d", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] e, input logic [31:0] obs);
    push(tag, e);
    compare(obs);
  endtask

  function automatic logic [31:0] st();
    return 32'(dut.r_state);
  endfunction

  initial begin
    int cnt;

    // reset and idle
    rst_n  = 1'b0;
    gate   = 1'b0;
    snd_in = 1'b1;
    step(3);
    chk("rst_state", 32'(ST_IDLE), st());
    chk("rst_outputs", 32'd0, {22'd0, snd_out, busy, env_level});
    rst_n = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step();
      chk("idle_quiet", 32'd0, {22'd0, snd_out, busy, env_level});
    end

    // attack ramp 0 -> 16, one step per 4 clocks, SUSTAIN at 64
    gate = 1'b1;
    for (int k = 0; k <= 64; k++) begin
      push("atk_level", 32'(k / 4));
      push("atk_state", (k < 64) ? 32'(ST_ATTACK) : 32'(ST_SUSTAIN));
      push("atk_busy", 32'd1);
    end
    for (int k = 0; k <= 64; k++) begin
      step();
      compare(32'(env_level));
      compare(st());
      compare(32'(busy));
    end

    // dither density at level 16
    step(20);
    cnt = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      cnt += int'(snd_out);
    end
    chk("dither_density", 32'd16, 32'(cnt));
    chk("sustain_hold", 32'd16, 32'(env_level));

    // release ramp 16 -> 0, one step per 8 clocks, IDLE one cycle later
    gate = 1'b0;
    for (int k = 0; k <= 129; k++) begin
      push("rel_level", (k <= 128) ? 32'(16 - k / 8) : 32'd0);
      push("rel_state", (k <= 128) ? 32'(ST_RELEASE) : 32'(ST_IDLE));
      push("rel_busy", (k <= 128) ? 32'd1 : 32'd0);
    end
    for (int k = 0; k <= 129; k++) begin
      step();
      compare(32'(env_level));
      compare(st());
      compare(32'(busy));
    end

    // retrigger from level 10 during release
    gate = 1'b1;
    step(65);
    chk("reatk_sustain", 32'(ST_SUSTAIN), st());
    gate = 1'b0;
    step(49);
    chk("rel_at_10_level", 32'd10, 32'(env_level));
    chk("rel_at_10_state", 32'(ST_RELEASE), st());
    gate = 1'b1;
    for (int k = 0; k <= 24; k++) begin
      push("retrig_level", 32'(10 + k / 4));
      push("retrig_state", (k < 24) ? 32'(ST_ATTACK) : 32'(ST_SUSTAIN));
    end
    for (int k = 0; k <= 24; k++) begin
      step();
      compare(32'(env_level));
      compare(st());
    end

    // snd_in low blocks output regardless of dither
    snd_in = 1'b0;
    step();
    cnt = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      cnt += int'(snd_out);
    end
    chk("snd_in_low", 32'd0, 32'(cnt));

    // mid-attack reset at level 7
    gate  = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n  = 1'b1;
    gate   = 1'b1;
    snd_in = 1'b1;
    step();
    chk("restart_state", 32'(ST_ATTACK), st());
    step(28);
    chk("pre_rst_level", 32'd7, 32'(env_level));
    chk("pre_rst_state", 32'(ST_ATTACK), st());
    rst_n = 1'b0;
    step();
    chk("mid_rst_state", 32'(ST_IDLE), st());
    chk("mid_rst_outputs", 32'd0, {22'd0, snd_out, busy, env_level});
    rst_n = 1'b1;
    step();
    chk("post_rst_state", 32'(ST_ATTACK), st());
    chk("post_rst_level", 32'd0, 32'(env_level));
    chk("post_rst_busy", 32'd1, 32'(busy));
    step(4);
    chk("post_rst_step", 32'd1, 32'(env_level));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_logs_envelope
`default_nettype wire
